// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : iterative restoring divider, one quotient bit per clock.
//
// A start accepted in IDLE latches the operands and runs WIDTH iterations
// (RUN), then spends one cycle in FIN, where the result registers are
// loaded and done is raised.  done is a one-cycle pulse that is visible in
// the first IDLE cycle after FIN, and q/r/div_by_zero hold their values
// until the next operation reaches FIN.  A zero divisor skips RUN and goes
// straight to FIN.
//
// Optional feature macro: DIVIDER_SIGNED_EN
//   When defined, signed_op=1 runs a two's-complement division that
//   truncates toward zero.  The operands are converted to magnitudes when
//   they are accepted, and the signs are applied again in FIN.  When the
//   macro is not defined, signed_op is ignored and every operation is
//   unsigned.
// ---------------------------------------------------------------------------
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t           state_q;

   // Working registers of the iteration.  The dividend is shifted left one
   // bit per step, so its MSB is always the next dividend bit to bring down.
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [CNT_W-1:0] cnt_q;
   logic             dbz_q;

   // Registered outputs
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] r_q;
   logic             dbz_out_q;

   // Operand values loaded at start, and the step/result combinational terms
   logic [WIDTH-1:0] a_load_s;
   logic [WIDTH-1:0] b_load_s;
   logic [WIDTH:0]   rprime_s;
   logic [WIDTH-1:0] diff_s;
   logic             qbit_s;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] fin_q_s;
   logic [WIDTH-1:0] fin_r_s;
   logic             b_zero_s;

   assign b_zero_s = (b == {WIDTH{1'b0}});

`ifdef DIVIDER_SIGNED_EN
   // Sign of the quotient and of the remainder, captured at start
   logic neg_q_q;
   logic neg_r_q;
   logic neg_q_load_s;
   logic neg_r_load_s;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Convert signed operands to magnitudes and record the sign rules of the result
   always_comb begin
      a_load_s     = a;
      b_load_s     = b;
      neg_q_load_s = 1'b0;
      neg_r_load_s = 1'b0;
      if (signed_op) begin
         if (a[WIDTH-1]) begin
            a_load_s = negate(a);
         end else begin
            a_load_s = a;
         end
         if (b[WIDTH-1]) begin
            b_load_s = negate(b);
         end else begin
            b_load_s = b;
         end
         neg_q_load_s = a[WIDTH-1] ^ b[WIDTH-1];
         neg_r_load_s = a[WIDTH-1];
      end else begin
         neg_q_load_s = 1'b0;
         neg_r_load_s = 1'b0;
      end
   end

   // Final result: all ones with r = a on a zero divisor, otherwise the magnitudes with the signs applied
   always_comb begin
      fin_q_s = quo_q;
      fin_r_s = rem_q;
      if (dbz_q) begin
         fin_q_s = {WIDTH{1'b1}};
         if (neg_r_q) begin
            fin_r_s = negate(a_q);
         end else begin
            fin_r_s = a_q;
         end
      end else begin
         if (neg_q_q) begin
            fin_q_s = negate(quo_q);
         end else begin
            fin_q_s = quo_q;
         end
         if (neg_r_q) begin
            fin_r_s = negate(rem_q);
         end else begin
            fin_r_s = rem_q;
         end
      end
   end
`else
   // signed_op has no effect in this build
   logic unused_signed_op_s;
   assign unused_signed_op_s = signed_op;

   assign a_load_s = a;
   assign b_load_s = b;

   // Final result: all ones with r = a on a zero divisor, otherwise the quotient and remainder as computed
   always_comb begin
      fin_q_s = quo_q;
      fin_r_s = rem_q;
      if (dbz_q) begin
         fin_q_s = {WIDTH{1'b1}};
         fin_r_s = a_q;
      end else begin
         fin_q_s = quo_q;
         fin_r_s = rem_q;
      end
   end
`endif

   // One restoring step.  r' = 2R + next dividend bit, held in WIDTH+1 bits.
   // R < B, so r' < 2B.  After a successful subtract, r' - B < B, so the
   // low WIDTH bits of the difference are exact.
   always_comb begin
      rprime_s = {rem_q, a_q[WIDTH-1]};
      diff_s   = rprime_s[WIDTH-1:0] - b_q;
      if (rprime_s >= {1'b0, b_q}) begin
         qbit_s = 1'b1;
         rem_d  = diff_s;
      end else begin
         qbit_s = 1'b0;
         rem_d  = rprime_s[WIDTH-1:0];
      end
      quo_d = {quo_q[WIDTH-2:0], qbit_s};
   end

   // Control FSM with datapath and registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         a_q       <= {WIDTH{1'b0}};
         b_q       <= {WIDTH{1'b0}};
         rem_q     <= {WIDTH{1'b0}};
         quo_q     <= {WIDTH{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         q_q       <= {WIDTH{1'b0}};
         r_q       <= {WIDTH{1'b0}};
         dbz_out_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q    <= a_load_s;
                  b_q    <= b_load_s;
                  rem_q  <= {WIDTH{1'b0}};
                  quo_q  <= {WIDTH{1'b0}};
                  cnt_q  <= CNT_W'(WIDTH - 1);
                  dbz_q  <= b_zero_s;
                  busy_q <= 1'b1;
`ifdef DIVIDER_SIGNED_EN
                  neg_q_q <= neg_q_load_s;
                  neg_r_q <= neg_r_load_s;
`endif
                  if (b_zero_s) begin
                     state_q <= ST_FIN;
                  end else begin
                     state_q <= ST_RUN;
                  end
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               done_q <= 1'b0;
               busy_q <= 1'b1;
               rem_q  <= rem_d;
               quo_q  <= quo_d;
               a_q    <= {a_q[WIDTH-2:0], 1'b0};
               cnt_q  <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_q <= ST_FIN;
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_FIN: begin
               q_q       <= fin_q_s;
               r_q       <= fin_r_s;
               dbz_out_q <= dbz_q;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign q           = q_q;
   assign r           = r_q;
   assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : directed and random checks of seq_divider (WIDTH=32).
// Expected results come from plain '/' and '%' arithmetic.  Expected
// latencies come from the edge counts of the done/busy handshake.
// ---------------------------------------------------------------------------
module tb_seq_divider;
   localparam int W = 32;

   logic         clock;
   logic         reset_n;
   logic         start;
   logic         signed_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] prev_q;
   logic [W-1:0] prev_r;
   logic         prev_z;

   seq_divider #(.WIDTH(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .signed_op   (signed_op),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .q           (q),
      .r           (r),
      .div_by_zero (div_by_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: results follow directly from the arithmetic definition
   function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                 input logic sop, output logic [W-1:0] eq,
                                 output logic [W-1:0] er, output logic ez);
      ez = (tb_v == 32'd0);
      if (tb_v == 32'd0) begin
         eq = 32'hFFFF_FFFF;
         er = ta;
      end
`ifdef DIVIDER_SIGNED_EN
      else if (sop) begin
         if (ta == 32'h8000_0000 && tb_v == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000;
            er = 32'd0;
         end else begin
            eq = $signed(ta) / $signed(tb_v);
            er = $signed(ta) % $signed(tb_v);
         end
      end
`endif
      else begin
         eq = ta / tb_v;
         er = ta % tb_v;
      end
   endfunction

   // Issue one operation and check the handshake, latency and result.
   // With hold set, start stays high and the operands keep changing while busy.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic sop, input bit hold);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         ez;
      int           n;
      int           busy_cnt;
      int           lat;
      model(ta, tb_v, sop, eq, er, ez);
      lat       = (tb_v == 32'd0) ? 1 : W + 1;
      a         = ta;
      b         = tb_v;
      signed_op = sop;
      start     = 1'b1;
      @(posedge clock); #1;
      if (!hold) start = 1'b0;
      chk({tag, "_hold_q"}, q, prev_q);
      chk({tag, "_hold_r"}, r, prev_r);
      chk({tag, "_hold_z"}, div_by_zero, prev_z);
      n        = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && n < 200) begin
         if (busy === 1'b1) busy_cnt++;
         if (hold) begin
            a         = $urandom;
            b         = $urandom;
            signed_op = 1'($urandom_range(0, 1));
         end
         @(posedge clock); #1;
         n++;
      end
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_busy_cycles"}, busy_cnt, lat);
      chk({tag, "_q"}, q, eq);
      chk({tag, "_r"}, r, er);
      chk({tag, "_dbz"}, div_by_zero, ez);
      chk({tag, "_busy_at_done"}, busy, 1'b0);
      prev_q = eq;
      prev_r = er;
      prev_z = ez;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      int           seen;

      reset_n   = 1'b0;
      start     = 1'b0;
      signed_op = 1'b0;
      a         = 32'd0;
      b         = 32'd0;
      prev_q    = 32'd0;
      prev_r    = 32'd0;
      prev_z    = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q", q, 32'd0);
      chk("rst_r", r, 32'd0);
      chk("rst_dbz", div_by_zero, 1'b0);
      reset_n = 1'b1;
      @(posedge clock); #1;

      // Basic unsigned division and single-cycle done pulse
      run_op("basic", 32'd100, 32'd7, 1'b0, 1'b0);
      chk("basic_q_const", q, 32'd14);
      chk("basic_r_const", r, 32'd2);
      @(posedge clock); #1;
      chk("done_pulse", done, 1'b0);
      chk("q_held_idle", q, 32'd14);

      // Wide remainder needs the extra bit of r'
      run_op("wide", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
      chk("wide_q_const", q, 32'd1);
      chk("wide_r_const", r, 32'h7FFF_FFFE);

      // Divide by zero, then a valid divide clears the flag
      run_op("dbz", 32'd55, 32'd0, 1'b0, 1'b0);
      chk("dbz_q_const", q, 32'hFFFF_FFFF);
      chk("dbz_r_const", r, 32'd55);
      chk("dbz_flag_const", div_by_zero, 1'b1);
      run_op("after_dbz", 32'd1000, 32'd5, 1'b0, 1'b0);
      chk("after_dbz_flag", div_by_zero, 1'b0);
      chk("after_dbz_q_const", q, 32'd200);

      // start held high throughout, with the operands changing while busy
      run_op("held", 32'd1234567, 32'd89, 1'b0, 1'b1);
      run_op("post_fin", 32'd999999, 32'd1000, 1'b0, 1'b0);
      chk("post_fin_q_const", q, 32'd999);

      // Asynchronous reset in the middle of RUN
      a = 32'd5000; b = 32'd3; signed_op = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_q", q, 32'd0);
      chk("arst_r", r, 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      chk("arst_no_done", seen, 0);
      prev_q = 32'd0;
      prev_r = 32'd0;
      prev_z = 1'b0;
      run_op("after_arst", 32'd5000, 32'd3, 1'b0, 1'b0);

      // Signed operations (unsigned results when the feature is absent)
`ifdef DIVIDER_SIGNED_EN
      run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      chk("s_m7_2_q_const", q, 32'hFFFF_FFFD);
      chk("s_m7_2_r_const", r, 32'hFFFF_FFFF);
      run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      chk("s_ovf_q_const", q, 32'h8000_0000);
      chk("s_ovf_r_const", r, 32'd0);
      run_op("s_dbz", 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);
`else
      run_op("nos_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      chk("nos_m7_2_q_const", q, 32'h7FFF_FFFC);
      chk("nos_m7_2_r_const", r, 32'd1);
`endif
      run_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      chk("u_m7_2_q_const", q, 32'h7FFF_FFFC);
      chk("u_m7_2_r_const", r, 32'd1);

      // Random operands, including small and zero divisors
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'($urandom_range(0, 3));
            1:       rb = 32'($urandom_range(1, 255));
            default: rb = $urandom;
         endcase
         rs = 1'($urandom_range(0, 1));
         run_op("rand", ra, rb, rs, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
